// File: rtl/execute_mc.sv
// rtl/execute_mc.sv - execute stage ALU with operand forwarding and a multi-cycle MUL/DIVU/REMU unit
module execute_mc #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_e,
  input  logic [WIDTH-1:0] rd1E,
  input  logic [WIDTH-1:0] rd2E,
  input  logic [WIDTH-1:0] ExtImmE,
  input  logic [WIDTH-1:0] ResultW,
  input  logic [WIDTH-1:0] ALUOutM,
  input  logic [1:0]       ForwardAE,
  input  logic [1:0]       ForwardBE,
  input  logic             ALUSrcE,
  input  logic [3:0]       ALUControlE,
  input  logic             flush_e,
  output logic [WIDTH-1:0] WriteDataE,
  output logic [WIDTH-1:0] ALUResultE,
  output logic [3:0]       ALUFlagsE,
  output logic             res_valid_e,
  output logic             stall_e
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [CNT_W-1:0] W_CNT = CNT_W'(WIDTH);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] op_a, op_b, acc, rem;
  logic [3:0]       op_q;

  logic [WIDTH-1:0] src_a, src_b, fwd_b;
  logic [WIDTH:0]   add_sum, sub_sum;
  logic [CNT_W-1:0] shamt;
  logic [WIDTH-1:0] sc_result;
  logic             sc_c, sc_v;
  logic             is_mc, start;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff, div_rem_next, div_q_next, mc_result;

  always_comb begin
    case (ForwardAE)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = ALUOutM;
      default: src_a = rd1E;
    endcase
    case (ForwardBE)
      2'b01:   fwd_b = ResultW;
      2'b10:   fwd_b = ALUOutM;
      default: fwd_b = rd2E;
    endcase
  end

  assign WriteDataE = fwd_b;
  assign src_b      = ALUSrcE ? ExtImmE : fwd_b;
  assign add_sum    = {1'b0, src_a} + {1'b0, src_b};
  assign sub_sum    = {1'b0, src_a} + {1'b0, ~src_b} + (WIDTH+1)'(1);
  assign shamt      = src_b[CNT_W-1:0];
  assign is_mc      = ALUControlE inside {4'd8, 4'd9, 4'd10};
  assign start      = (state == IDLE) && rst_n && valid_e && !flush_e && is_mc;

  always_comb begin
    sc_result = '0;
    sc_c      = 1'b0;
    sc_v      = 1'b0;
    case (ALUControlE)
      4'd0: begin
        sc_result = add_sum[WIDTH-1:0];
        sc_c      = add_sum[WIDTH];
        sc_v      = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sc_result[WIDTH-1] != src_a[WIDTH-1]);
      end
      4'd1, 4'd7: begin
        sc_result = sub_sum[WIDTH-1:0];
        sc_c      = sub_sum[WIDTH];
        sc_v      = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (sc_result[WIDTH-1] != src_a[WIDTH-1]);
      end
      4'd2: sc_result = src_a & src_b;
      4'd3: sc_result = src_a | src_b;
      4'd4: sc_result = src_a ^ src_b;
      4'd5: sc_result = (shamt >= W_CNT) ? '0 : src_a << shamt;
      4'd6: sc_result = (shamt >= W_CNT) ? '0 : src_a >> shamt;
      default: sc_result = '0;
    endcase
  end

  // Restoring division: op_a shifts the dividend out and the quotient in; a zero divisor yields all-ones / dividend.
  assign div_shift    = {rem, op_a[WIDTH-1]};
  assign div_ge       = div_shift >= {1'b0, op_b};
  assign div_diff     = div_shift[WIDTH-1:0] - op_b;
  assign div_rem_next = div_ge ? div_diff : div_shift[WIDTH-1:0];
  assign div_q_next   = {op_a[WIDTH-2:0], div_ge};

  always_comb begin
    case (op_q)
      4'd8:    mc_result = acc;
      4'd9:    mc_result = op_a;
      default: mc_result = rem;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      op_a  <= '0;
      op_b  <= '0;
      op_q  <= '0;
      acc   <= '0;
      rem   <= '0;
    end else begin
      state <= state_n;
      if (start) begin
        op_a <= src_a;
        op_b <= src_b;
        op_q <= ALUControlE;
        acc  <= '0;
        rem  <= '0;
        cnt  <= W_CNT;
      end else if (state == BUSY) begin
        cnt <= cnt - CNT_W'(1);
        if (op_q == 4'd8) begin
          if (op_b[0]) acc <= acc + op_a;
          op_a <= op_a << 1;
          op_b <= op_b >> 1;
        end else begin
          rem  <= div_rem_next;
          op_a <= div_q_next;
        end
      end
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = BUSY;
      BUSY:    if (cnt == CNT_W'(1)) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (flush_e) state_n = IDLE;
  end

  // Outputs are forced quiet while rst_n is low so no stall or result leaks during reset.
  always_comb begin
    ALUResultE  = '0;
    ALUFlagsE   = '0;
    res_valid_e = 1'b0;
    stall_e     = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          if (is_mc) begin
            stall_e = start;
          end else begin
            ALUResultE  = sc_result;
            res_valid_e = valid_e && !flush_e;
            if (ALUControlE <= 4'd7)
              ALUFlagsE = {sc_result[WIDTH-1], sc_result == '0, sc_c, sc_v};
          end
        end
        BUSY: stall_e = !flush_e;
        DONE: begin
          ALUResultE  = mc_result;
          ALUFlagsE   = {mc_result[WIDTH-1], mc_result == '0, 2'b00};
          res_valid_e = !flush_e;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_mc.sv
// tb/tb_execute_mc.sv - directed self-checking bench for execute_mc (WIDTH=8)
module tb_execute_mc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_e;
  logic [7:0] rd1E, rd2E, ExtImmE, ResultW, ALUOutM;
  logic [1:0] ForwardAE, ForwardBE;
  logic       ALUSrcE;
  logic [3:0] ALUControlE;
  logic       flush_e;
  logic [7:0] WriteDataE, ALUResultE;
  logic [3:0] ALUFlagsE;
  logic       res_valid_e, stall_e;

  int checks = 0;
  int errors = 0;

  execute_mc #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .valid_e(valid_e),
    .rd1E(rd1E), .rd2E(rd2E), .ExtImmE(ExtImmE),
    .ResultW(ResultW), .ALUOutM(ALUOutM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE), .flush_e(flush_e),
    .WriteDataE(WriteDataE), .ALUResultE(ALUResultE), .ALUFlagsE(ALUFlagsE),
    .res_valid_e(res_valid_e), .stall_e(stall_e)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    valid_e     = 1'b1;
    flush_e     = 1'b0;
    ForwardAE   = 2'b00;
    ForwardBE   = 2'b00;
    ALUSrcE     = 1'b0;
    ALUControlE = op;
    rd1E        = a;
    rd2E        = b;
  endtask

  task automatic single(input string tag, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] er, input logic [3:0] ef);
    @(negedge clk);
    drive(op, a, b);
    #1;
    chk({tag, "_res"}, ALUResultE, er);
    chk({tag, "_flags"}, ALUFlagsE, ef);
    chk({tag, "_valid"}, res_valid_e, 1'b1);
    chk({tag, "_stall"}, stall_e, 1'b0);
  endtask

  task automatic run_mc(input string tag, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] er, input logic [3:0] ef);
    int n;
    bit got;
    n = 0;
    got = 0;
    @(negedge clk);
    drive(op, a, b);
    #1;
    chk({tag, "_start_res"}, ALUResultE, 8'h00);
    for (int i = 0; i < 40; i++) begin
      if (res_valid_e) begin
        got = 1;
        break;
      end
      if (stall_e) n++;
      @(negedge clk);
      // operands and opcode must be ignored while busy
      rd1E        = 8'($urandom);
      rd2E        = 8'($urandom);
      ALUControlE = 4'd9;
      #1;
    end
    chk({tag, "_done"}, got, 1'b1);
    chk({tag, "_stall_cycles"}, n, 9);
    chk({tag, "_res"}, ALUResultE, er);
    chk({tag, "_flags"}, ALUFlagsE, ef);
    @(negedge clk);
    valid_e = 1'b0;
    #1;
    chk({tag, "_valid_1cyc"}, res_valid_e, 1'b0);
    chk({tag, "_stall_after"}, stall_e, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(4'd0, 8'h00, 8'h00);
    valid_e = 1'b0;
    ExtImmE = 8'h00;
    ResultW = 8'h00;
    ALUOutM = 8'h00;
    #12;
    chk("rst_stall", stall_e, 1'b0);
    chk("rst_valid", res_valid_e, 1'b0);
    chk("rst_res", ALUResultE, 8'h00);
    chk("rst_flags", ALUFlagsE, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;

    single("add_ovf", 4'd0, 8'h7F, 8'h01, 8'h80, 4'b1001);
    single("add_carry", 4'd0, 8'hFF, 8'h01, 8'h00, 4'b0110);
    single("sub_ovf", 4'd1, 8'h80, 8'h01, 8'h7F, 4'b0011);
    single("cmp_borrow", 4'd7, 8'h03, 8'h05, 8'hFE, 4'b1000);

    @(negedge clk);
    drive(4'd1, 8'h33, 8'h05);
    ForwardAE = 2'b10;
    ALUOutM   = 8'h05;
    ResultW   = 8'h09;
    #1;
    chk("sub_fwdM_res", ALUResultE, 8'h00);
    chk("sub_fwdM_flags", ALUFlagsE, 4'b0110);
    ForwardAE = 2'b01;
    #1;
    chk("sub_fwdW_res", ALUResultE, 8'h04);
    chk("sub_fwdW_flags", ALUFlagsE, 4'b0010);
    ForwardBE = 2'b01;
    #1;
    chk("writedata_fwd", WriteDataE, 8'h09);

    @(negedge clk);
    drive(4'd2, 8'hF0, 8'h00);
    ALUSrcE = 1'b1;
    ExtImmE = 8'h3C;
    #1;
    chk("and_imm", ALUResultE, 8'h30);
    chk("and_imm_wd", WriteDataE, 8'h00);

    single("sll1", 4'd5, 8'h81, 8'h01, 8'h02, 4'b0000);
    single("sll8", 4'd5, 8'h81, 8'h08, 8'h00, 4'b0100);
    single("srl7", 4'd6, 8'h80, 8'h07, 8'h01, 4'b0000);
    single("srl_lowbits", 4'd6, 8'h80, 8'h11, 8'h40, 4'b0000);
    single("srl15", 4'd6, 8'h80, 8'h0F, 8'h00, 4'b0100);
    single("xor", 4'd4, 8'h5A, 8'hFF, 8'hA5, 4'b1000);

    @(negedge clk);
    drive(4'd12, 8'h12, 8'h34);
    #1;
    chk("op12_res", ALUResultE, 8'h00);
    chk("op12_flags", ALUFlagsE, 4'h0);

    run_mc("mul", 4'd8, 8'h0D, 8'h0B, 8'h8F, 4'b1000);
    run_mc("divu", 4'd9, 8'hC8, 8'h07, 8'h1C, 4'b0000);
    run_mc("remu", 4'd10, 8'hC8, 8'h07, 8'h04, 4'b0000);
    run_mc("divu0", 4'd9, 8'hC8, 8'h00, 8'hFF, 4'b1000);
    run_mc("remu0", 4'd10, 8'hC8, 8'h00, 8'hC8, 4'b1000);

    // flush on the start cycle: no start
    @(negedge clk);
    drive(4'd8, 8'h02, 8'h03);
    flush_e = 1'b1;
    #1;
    chk("flush_start_stall", stall_e, 1'b0);
    @(negedge clk);
    valid_e = 1'b0;
    flush_e = 1'b0;
    #1;
    chk("flush_start_idle", stall_e, 1'b0);

    // flush in the 4th busy cycle
    @(negedge clk);
    drive(4'd8, 8'h0D, 8'h0B);
    for (int i = 0; i < 4; i++) @(negedge clk);
    flush_e = 1'b1;
    #1;
    chk("flush_busy_stall", stall_e, 1'b0);
    chk("flush_busy_valid", res_valid_e, 1'b0);
    @(negedge clk);
    flush_e = 1'b0;
    valid_e = 1'b0;
    #1;
    chk("flush_after_stall", stall_e, 1'b0);
    chk("flush_after_valid", res_valid_e, 1'b0);
    single("add_after_flush", 4'd0, 8'h10, 8'h22, 8'h32, 4'b0000);

    // reset mid-busy
    @(negedge clk);
    drive(4'd9, 8'hC8, 8'h07);
    for (int i = 0; i < 3; i++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_busy_stall", stall_e, 1'b0);
    chk("rst_busy_valid", res_valid_e, 1'b0);
    chk("rst_busy_res", ALUResultE, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'd4, 8'h5A, 8'hFF);
    #1;
    chk("post_rst_res", ALUResultE, 8'hA5);
    chk("post_rst_valid", res_valid_e, 1'b1);
    chk("post_rst_stall", stall_e, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
